// File: rtl/psum_drain_if.sv
// Row-in / lane-out handshake bundle for psum_drain.
// The slave modport is the drain; master is the array plus downstream side.
interface psum_drain_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int PSUM_W     = 32
);
  localparam int LW = $clog2(ARRAY_SIZE);

  logic                         psum_valid;
  logic                         psum_ready;
  logic [ARRAY_SIZE*PSUM_W-1:0] psums;
  logic                         out_valid;
  logic                         out_ready;
  logic [PSUM_W-1:0]            out_data;
  logic [LW-1:0]                out_lane;
  logic                         out_last;

  modport master (
    output psum_valid, psums, out_ready,
    input  psum_ready, out_valid, out_data, out_lane, out_last
  );

  modport slave (
    input  psum_valid, psums, out_ready,
    output psum_ready, out_valid, out_data, out_lane, out_last
  );
endinterface

// File: rtl/psum_drain.sv
// Systolic-array psum drain: row FIFO feeding a lane serializer.
// Optional PSUM_DRAIN_RELU_EN clamps negative lanes to zero on the output mux.
//
// state    | meaning
// S_IDLE   | FIFO empty, out_valid low
// S_STREAM | head row being serialized, out_valid high
module psum_drain #(
  parameter int ARRAY_SIZE = 8,
  parameter int PSUM_W     = 32,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  psum_drain_if.slave bus,
  output logic [15:0] rows_done
);
  localparam int ROW_W = ARRAY_SIZE * PSUM_W;
  localparam int LW    = $clog2(ARRAY_SIZE);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic [LW-1:0]    lane_q;
  logic             push, beat, lane_end, pop;
  logic [ROW_W-1:0] head_row;
  logic [PSUM_W-1:0] lane_val, data_sel;

  assign bus.psum_ready = (count_q != PW'(DEPTH));
  assign push     = bus.psum_valid && bus.psum_ready;
  assign beat     = bus.out_valid && bus.out_ready;
  assign lane_end = (lane_q == LW'(ARRAY_SIZE - 1));
  assign pop      = beat && lane_end;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + PW'(1);
    else if (pop && !push)
      count_d = count_q - PW'(1);
  end

  // Storage is not reset; out_data is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q[AW-1:0]] <= bus.psums;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lane_q    <= '0;
      rows_done <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (beat)
        lane_q <= lane_end ? '0 : lane_q + LW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PW'(1);
        rows_done <= rows_done + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (push) state_d = S_STREAM;
      S_STREAM: if (pop && count_d == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    head_row = mem[rd_ptr_q[AW-1:0]];
    lane_val = head_row[int'(lane_q)*PSUM_W +: PSUM_W];
`ifdef PSUM_DRAIN_RELU_EN
    data_sel = lane_val[PSUM_W-1] ? '0 : lane_val;
`else
    data_sel = lane_val;
`endif
    bus.out_valid = (state_q == S_STREAM);
    bus.out_lane  = lane_q;
    bus.out_last  = bus.out_valid && lane_end;
    bus.out_data  = bus.out_valid ? data_sel : '0;
  end
endmodule

// File: tb/tb_psum_drain.sv
// Directed self-checking bench for psum_drain (ARRAY_SIZE=8, PSUM_W=32, DEPTH=4).
module tb_psum_drain;
  localparam int AS = 8;
  localparam int PW = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rows_done;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  psum_drain_if #(.ARRAY_SIZE(AS), .PSUM_W(PW)) bus ();

  psum_drain #(.ARRAY_SIZE(AS), .PSUM_W(PW), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rows_done (rows_done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AS*PW-1:0] mk_row(input logic [31:0] base);
    logic [AS*PW-1:0] r;
    for (int k = 0; k < AS; k++) r[k*PW +: PW] = base + 32'(k);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.psum_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.psums = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if (bus.psum_ready !== 1'b1) $display("FAIL reset_psum_ready: got %b expected 1", bus.psum_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data: got %h expected 0", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_lane !== 3'd0) $display("FAIL reset_out_lane: got %0d expected 0", bus.out_lane); else pass_cnt++;
    total_cnt++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", bus.out_last); else pass_cnt++;
    total_cnt++; if (rows_done !== 16'd0) $display("FAIL reset_rows_done: got %0d expected 0", rows_done); else pass_cnt++;
  endtask

  task automatic test_single_row();
    logic [36:0] got, exp;
    do_reset();
    bus.out_ready = 1'b1;
    bus.psums = mk_row(32'd1);
    bus.psum_valid = 1'b1;
    @(negedge clk);
    bus.psum_valid = 1'b0;
    for (int k = 0; k < AS; k++) begin
      got = {bus.out_valid, bus.out_lane, bus.out_last, bus.out_data};
      exp = {1'b1, 3'(k), (k == AS-1), 32'(k+1)};
      total_cnt++; if (got !== exp) $display("FAIL single_beat%0d: got %h expected %h", k, got, exp); else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL single_idle: got %b expected 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (rows_done !== 16'd1) $display("FAIL single_rows_done: got %0d expected 1", rows_done); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat;
    logic [36:0] got, exp;
    int          e, cyc;
    pat = 4'b1001;
    do_reset();
    bus.psums = mk_row(32'h100);
    bus.psum_valid = 1'b1;
    @(negedge clk);
    bus.psum_valid = 1'b0;
    e = 0;
    cyc = 0;
    while (e < AS && cyc < 40) begin
      bus.out_ready = pat[3 - (cyc % 4)];
      got = {bus.out_valid, bus.out_lane, bus.out_last, bus.out_data};
      exp = {1'b1, 3'(e), (e == AS-1), 32'h100 + 32'(e)};
      total_cnt++; if (got !== exp) $display("FAIL bp_cyc%0d: got %h expected %h", cyc, got, exp); else pass_cnt++;
      if (bus.out_ready && bus.out_valid) e++;
      cyc++;
      @(negedge clk);
    end
    total_cnt++; if (e !== AS) $display("FAIL bp_beats: got %0d expected %0d", e, AS); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0 || rows_done !== 16'd1) $display("FAIL bp_end: got valid=%b rows=%0d expected valid=0 rows=1", bus.out_valid, rows_done); else pass_cnt++;
  endtask

  task automatic test_full_fifo();
    int beats, acc_beats;
    bit go;
    logic [31:0] ev;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.psums = mk_row(32'h1000 * (i + 1));
      bus.psum_valid = 1'b1;
      total_cnt++; if (bus.psum_ready !== 1'b1) $display("FAIL full_ready%0d: got %b expected 1", i, bus.psum_ready); else pass_cnt++;
      @(negedge clk);
    end
    bus.psums = mk_row(32'h5000);
    total_cnt++; if (bus.psum_ready !== 1'b0) $display("FAIL full_not_ready: got %b expected 0", bus.psum_ready); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.psum_ready !== 1'b0 || bus.out_data !== 32'h1000 || bus.out_lane !== 3'd0)
      $display("FAIL full_hold: got ready=%b data=%h lane=%0d expected ready=0 data=00001000 lane=0", bus.psum_ready, bus.out_data, bus.out_lane);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    beats = 0;
    acc_beats = -1;
    for (int cyc = 0; cyc < 100 && beats < 5*AS; cyc++) begin
      go = bus.psum_valid && bus.psum_ready;
      if (go) acc_beats = beats;
      if (bus.out_valid) begin
        ev = 32'h1000 * (beats / AS + 1) + 32'(beats % AS);
        total_cnt++; if (bus.out_data !== ev || bus.out_lane !== 3'(beats % AS))
          $display("FAIL full_beat%0d: got data=%h lane=%0d expected data=%h lane=%0d", beats, bus.out_data, bus.out_lane, ev, beats % AS);
        else pass_cnt++;
        beats++;
      end
      @(negedge clk);
      if (go) bus.psum_valid = 1'b0;
    end
    total_cnt++; if (acc_beats !== AS) $display("FAIL full_accept_time: got %0d expected %0d", acc_beats, AS); else pass_cnt++;
    total_cnt++; if (beats !== 5*AS) $display("FAIL full_beats: got %0d expected %0d", beats, 5*AS); else pass_cnt++;
    total_cnt++; if (rows_done !== 16'd5 || bus.out_valid !== 1'b0) $display("FAIL full_end: got rows=%0d valid=%b expected rows=5 valid=0", rows_done, bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int beats, sent, cyc;
    bit go;
    logic [31:0] ev;
    do_reset();
    bus.out_ready = 1'b1;
    sent = 0;
    beats = 0;
    bus.psums = mk_row(32'h20000);
    bus.psum_valid = 1'b1;
    cyc = 0;
    while (cyc < 400 && beats < 20*AS) begin
      if (bus.out_valid) begin
        ev = 32'h20000 + 32'(16 * (beats / AS)) + 32'(beats % AS);
        total_cnt++; if (bus.out_data !== ev || bus.out_lane !== 3'(beats % AS))
          $display("FAIL stream_beat%0d: got data=%h lane=%0d expected data=%h lane=%0d", beats, bus.out_data, bus.out_lane, ev, beats % AS);
        else pass_cnt++;
        beats++;
      end
      go = bus.psum_valid && bus.psum_ready;
      cyc++;
      @(negedge clk);
      if (go) begin
        sent++;
        if (sent < 20) bus.psums = mk_row(32'h20000 + 32'(16 * sent));
        else bus.psum_valid = 1'b0;
      end
    end
    total_cnt++; if (beats !== 20*AS || sent !== 20) $display("FAIL stream_count: got beats=%0d sent=%0d expected 160/20", beats, sent); else pass_cnt++;
    total_cnt++; if (cyc !== 20*AS + 1) $display("FAIL stream_throughput: got %0d cycles expected %0d", cyc, 20*AS + 1); else pass_cnt++;
    total_cnt++; if (rows_done !== 16'd20) $display("FAIL stream_rows_done: got %0d expected 20", rows_done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_row();
    int stale;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.psums = mk_row(32'h3000 + 32'(16 * i));
      bus.psum_valid = 1'b1;
      @(negedge clk);
    end
    bus.psum_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (AS + 4) @(negedge clk);
    total_cnt++; if (rows_done !== 16'd1 || bus.out_lane !== 3'd4 || bus.out_data !== 32'h3014)
      $display("FAIL mid_before: got rows=%0d lane=%0d data=%h expected rows=1 lane=4 data=00003014", rows_done, bus.out_lane, bus.out_data);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0 || rows_done !== 16'd0) $display("FAIL mid_async: got valid=%b rows=%0d expected 0/0", bus.out_valid, rows_done); else pass_cnt++;
    total_cnt++; if (bus.psum_ready !== 1'b1 || bus.out_lane !== 3'd0) $display("FAIL mid_async_state: got ready=%b lane=%0d expected 1/0", bus.psum_ready, bus.out_lane); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale++;
    end
    total_cnt++; if (stale !== 0 || rows_done !== 16'd0) $display("FAIL mid_stale: got stale=%0d rows=%0d expected 0/0", stale, rows_done); else pass_cnt++;
    bus.psums = mk_row(32'h4000);
    bus.psum_valid = 1'b1;
    @(negedge clk);
    bus.psum_valid = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_lane !== 3'd0 || bus.out_data !== 32'h4000)
      $display("FAIL mid_recover: got valid=%b lane=%0d data=%h expected 1/0/00004000", bus.out_valid, bus.out_lane, bus.out_data);
    else pass_cnt++;
    repeat (AS) @(negedge clk);
  endtask

  task automatic test_relu();
    logic [AS*PW-1:0] r;
    logic [31:0] exp [4];
    r = '0;
    r[0*PW +: PW] = 32'hFFFF_FFFF;
    r[1*PW +: PW] = 32'h0000_0005;
    r[2*PW +: PW] = 32'h8000_0000;
    r[3*PW +: PW] = 32'h7FFF_FFFF;
`ifdef PSUM_DRAIN_RELU_EN
    exp[0] = 32'h0; exp[1] = 32'h5; exp[2] = 32'h0; exp[3] = 32'h7FFF_FFFF;
`else
    exp[0] = 32'hFFFF_FFFF; exp[1] = 32'h5; exp[2] = 32'h8000_0000; exp[3] = 32'h7FFF_FFFF;
`endif
    do_reset();
    bus.out_ready = 1'b1;
    bus.psums = r;
    bus.psum_valid = 1'b1;
    @(negedge clk);
    bus.psum_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k])
        $display("FAIL relu_lane%0d: got valid=%b data=%h expected valid=1 data=%h", k, bus.out_valid, bus.out_data, exp[k]);
      else pass_cnt++;
      @(negedge clk);
    end
    repeat (AS) @(negedge clk);
  endtask

  initial begin
    bus.psum_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.psums = '0;
    test_reset();
    test_single_row();
    test_backpressure();
    test_full_fifo();
    test_back_to_back();
    test_reset_mid_row();
    test_relu();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
